// File: rtl/instruction_sequencer_pkg.sv
// Shared ISA types and widths for the mini serial processor sequencer.
//   instruction_t     : {op_code[1:0], rs_1[9:0], rs_2[9:0], rd[9:0]}, MSB first
//   alu_packet_t      : {op_2, op_1, op_code}, shifted to the ALU from bit 0 up
//   sequencer_state_t : FSM states of instruction_sequencer
package instruction_sequencer_pkg;

    localparam int REGISTER_SIZE      = 32;
    localparam int REGISTER_BANK_SIZE = 1024;
    localparam int AW                 = $clog2(REGISTER_BANK_SIZE);

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_code_t;

    typedef struct packed {
        op_code_t          op_code;
        logic [AW-1:0]     rs_1;
        logic [AW-1:0]     rs_2;
        logic [AW-1:0]     rd;
    } instruction_t;

    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
        op_code_t                 op_code;
    } alu_packet_t;

    localparam int ALU_PACKET_WIDTH = $bits(alu_packet_t);
    localparam int RESULT_WIDTH     = REGISTER_SIZE;

    // bit_cnt only ever counts to 65 (SEND) or 31 (RECV)
    localparam int                CNT_W   = 7;
    localparam logic [CNT_W-1:0]  TX_LAST = CNT_W'(ALU_PACKET_WIDTH - 1);
    localparam logic [CNT_W-1:0]  RX_LAST = CNT_W'(RESULT_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, LATCH, SEND, RECV, WRITE} sequencer_state_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Bus bundle around the sequencer: instruction handshake, register bank
// read/write port, serial ALU link and status.
//   master : sequencer side (drives instr_ready, rf_*, alu_tx_*, busy, done)
//   slave  : environment side (instruction source, register bank, ALU)
interface instruction_sequencer_if;
    import instruction_sequencer_pkg::*;

    logic                     instr_valid;
    logic                     instr_ready;
    logic [REGISTER_SIZE-1:0] instr;
    logic [AW-1:0]            rf_raddr;
    logic [REGISTER_SIZE-1:0] rf_rdata;
    logic                     rf_we;
    logic [AW-1:0]            rf_waddr;
    logic [REGISTER_SIZE-1:0] rf_wdata;
    logic                     alu_tx_start;
    logic                     alu_tx_bit;
    logic                     alu_rx_valid;
    logic                     alu_rx_bit;
    logic                     busy;
    logic                     done;

    modport master (
        input  instr_valid, instr, rf_rdata, alu_rx_valid, alu_rx_bit,
        output instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_tx_start, alu_tx_bit, busy, done
    );

    modport slave (
        output instr_valid, instr, rf_rdata, alu_rx_valid, alu_rx_bit,
        input  instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_tx_start, alu_tx_bit, busy, done
    );

endinterface

// File: rtl/instruction_sequencer_serial_shifter.sv
// serial_shifter: WIDTH-bit right shifter with parallel load.
//   clock, reset : rising edge, asynchronous active-high reset
//   load         : data <= load_data (wins over shift)
//   shift        : data <= {serial_in, data[WIDTH-1:1]}
//   data         : parallel contents; data[0] is the serial output bit
module serial_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      data <= '0;
        else if (load)  data <= load_data;
        else if (shift) data <= {serial_in, data[WIDTH-1:1]};
    end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: runs one instruction at a time. Reads rs_1/rs_2,
// ships {op_2, op_1, op_code} LSB first to the serial ALU, collects the
// 32-bit result LSB first and writes it to rd.
//   clock, reset : rising edge, asynchronous active-high reset
//   bus (master) : instruction handshake, register bank ports, ALU serial
//                  link, busy and done
// Build option SEQ_ZERO_REG_EN: register 0 reads as zero and writes to it
// are suppressed (done still pulses).
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    instruction_sequencer_if.master  bus
);

    sequencer_state_t         state, state_nx;
    instruction_t             ir;
    logic [REGISTER_SIZE-1:0] op_1;
    logic [CNT_W-1:0]         bit_cnt;
    logic [REGISTER_SIZE-1:0] rdata_a, rdata_b;
    logic                     wb_en;
    logic                     tx_load, tx_shift, rx_shift;
    alu_packet_t              tx_pkt;
    logic [ALU_PACKET_WIDTH-1:0] tx_data;
    logic [RESULT_WIDTH-1:0]  result;
    logic                     tx_unused;

`ifdef SEQ_ZERO_REG_EN
    // Mask against the latched address, not rf_raddr, which has already moved on
    assign rdata_a = (ir.rs_1 == '0) ? '0 : bus.rf_rdata;
    assign rdata_b = (ir.rs_2 == '0) ? '0 : bus.rf_rdata;
    assign wb_en   = (ir.rd != '0);
`else
    assign rdata_a = bus.rf_rdata;
    assign rdata_b = bus.rf_rdata;
    assign wb_en   = 1'b1;
`endif

    assign tx_pkt = '{op_2: rdata_b, op_1: op_1, op_code: ir.op_code};

    serial_shifter #(.WIDTH(ALU_PACKET_WIDTH)) u_tx (
        .clock(clock), .reset(reset),
        .load(tx_load), .load_data(tx_pkt),
        .shift(tx_shift), .serial_in(1'b0),
        .data(tx_data)
    );

    serial_shifter #(.WIDTH(RESULT_WIDTH)) u_rx (
        .clock(clock), .reset(reset),
        .load(tx_load), .load_data('0),
        .shift(rx_shift), .serial_in(bus.alu_rx_bit),
        .data(result)
    );

    // Upper tx bits are only ever observed once they reach bit 0
    assign tx_unused = ^tx_data[ALU_PACKET_WIDTH-1:1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ir      <= '0;
            op_1    <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE:    if (bus.instr_valid) ir <= bus.instr;
                RD_B:    op_1 <= rdata_a;
                LATCH:   bit_cnt <= '0;
                SEND:    bit_cnt <= (bit_cnt == TX_LAST) ? '0 : bit_cnt + 1'b1;
                RECV:    if (bus.alu_rx_valid)
                             bit_cnt <= (bit_cnt == RX_LAST) ? '0 : bit_cnt + 1'b1;
                default: bit_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nx         = state;
        bus.instr_ready  = 1'b0;
        bus.rf_raddr     = '0;
        bus.rf_we        = 1'b0;
        bus.rf_waddr     = '0;
        bus.rf_wdata     = '0;
        bus.alu_tx_start = 1'b0;
        bus.alu_tx_bit   = 1'b0;
        bus.done         = 1'b0;
        tx_load          = 1'b0;
        tx_shift         = 1'b0;
        rx_shift         = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_nx = RD_A;
            end
            RD_A: begin
                bus.rf_raddr = ir.rs_1;
                state_nx     = RD_B;
            end
            RD_B: begin
                bus.rf_raddr = ir.rs_2;
                state_nx     = LATCH;
            end
            LATCH: begin
                tx_load  = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                bus.alu_tx_bit   = tx_data[0];
                bus.alu_tx_start = (bit_cnt == '0);
                tx_shift         = 1'b1;
                if (bit_cnt == TX_LAST) state_nx = RECV;
            end
            RECV: begin
                rx_shift = bus.alu_rx_valid;
                if (bus.alu_rx_valid && bit_cnt == RX_LAST) state_nx = WRITE;
            end
            WRITE: begin
                bus.rf_we    = wb_en;
                bus.rf_waddr = ir.rd;
                bus.rf_wdata = result;
                bus.done     = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: register bank model, serial ALU model
// (ADD/SUB/AND/OR), directed vector table plus back-to-back, mid-SEND reset
// and register-0 sequences.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [9:0]  ra;
        logic [31:0] va;
        logic [9:0]  rb;
        logic [31:0] vb;
        bit          stall;
        logic [9:0]  exp_addr;
        logic [31:0] exp_data;
        logic [65:0] exp_pkt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_sequencer_if bus();

    instruction_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Register bank: synchronous read, write from DUT or bench preset
    logic [31:0] regs [1024];
    logic        pre_en   = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clock) begin
        bus.rf_rdata <= regs[bus.rf_raddr];
        if (bus.rf_we) regs[bus.rf_waddr] <= bus.rf_wdata;
        if (pre_en)    regs[pre_addr] <= pre_data;
    end

    // Monitor / ALU model state
    int          cyc = 0, tx_cnt = 0, rx_left = 0, rx_idx = 0;
    int          stalls = 0, start_bad = 0, ready_bad = 0;
    int          hs_count = 0, done_count = 0, we_count = 0;
    int          hs_cyc = 0, done_cyc = 0, we_cyc = 0;
    bit          stall_en = 1'b0, in_flight = 1'b0;
    logic [65:0] pkt = '0, last_pkt = '0;
    logic [31:0] alu_result = '0, last_wdata = '0;
    logic [9:0]  last_waddr = '0;

    int passed = 0, total = 0;

    function automatic logic [31:0] alu_model(input logic [65:0] p);
        logic [31:0] a, b;
        a = p[33:2];
        b = p[65:34];
        case (p[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Everything observed and driven at the falling edge, mid-cycle
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                tx_cnt = 0;
                rx_left = 0;
                in_flight = 1'b0;
                bus.alu_rx_valid = 1'b0;
                bus.alu_rx_bit = 1'b0;
            end else begin
                if (rx_left > 0) begin
                    if (bus.alu_rx_valid) begin
                        rx_idx++;
                        rx_left--;
                    end
                    if (rx_left > 0) begin
                        bus.alu_rx_valid = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
                        if (!bus.alu_rx_valid) stalls++;
                        bus.alu_rx_bit = alu_result[rx_idx];
                    end else begin
                        bus.alu_rx_valid = 1'b0;
                        bus.alu_rx_bit = 1'b0;
                    end
                end
                if (bus.alu_tx_start && tx_cnt != 0) start_bad++;
                if (bus.alu_tx_start || tx_cnt > 0) begin
                    pkt[tx_cnt] = bus.alu_tx_bit;
                    tx_cnt++;
                    if (tx_cnt == 66) begin
                        last_pkt = pkt;
                        alu_result = alu_model(pkt);
                        rx_left = 32;
                        rx_idx = 0;
                        tx_cnt = 0;
                    end
                end
                if (in_flight && bus.instr_ready) ready_bad++;
                if (bus.rf_we) begin
                    we_count++;
                    we_cyc = cyc;
                    last_waddr = bus.rf_waddr;
                    last_wdata = bus.rf_wdata;
                end
                if (bus.done) begin
                    done_count++;
                    done_cyc = cyc;
                    in_flight = 1'b0;
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    hs_count++;
                    hs_cyc = cyc;
                    in_flight = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preset(input logic [9:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic wait_hs(input int h0, input string tag);
        int t = 0;
        while (hs_count == h0 && t < 50) begin
            tick();
            t++;
        end
        check({tag, ".accepted"}, 66'(hs_count - h0), 66'(1));
    endtask

    task automatic wait_done(input int d0, input string tag);
        int t = 0;
        while (done_count == d0 && t < 600) begin
            tick();
            t++;
        end
        check({tag, ".done"}, 66'(done_count - d0), 66'(1));
    endtask

    task automatic issue(input logic [31:0] ins, input string tag);
        int h0 = hs_count;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        wait_hs(h0, tag);
        bus.instr_valid = 1'b0;
        bus.instr = '0;
    endtask

    vec_t vecs [5];
    int   d0, d1, h0, w0, t;

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.alu_rx_valid = 1'b0;
        bus.alu_rx_bit = 1'b0;

        vecs[0] = '{"add_basic", 32'h12AF7642, 10'h12A, 32'd5, 10'h3DD, 32'd3, 1'b0,
                    10'h242, 32'd8, {32'd3, 32'd5, 2'b00}};
        vecs[1] = '{"sub_stall", 32'h41108833, 10'h011, 32'h10, 10'h022, 32'h1, 1'b1,
                    10'h033, 32'hF, {32'h1, 32'h10, 2'b01}};
        vecs[2] = '{"and_mix", 32'h900BFC05, 10'h100, 32'hF0F0_1234, 10'h2FF, 32'h0FF0_FF00, 1'b0,
                    10'h005, 32'h00F0_1200, {32'h0FF0_FF00, 32'hF0F0_1234, 2'b10}};
        vecs[3] = '{"or_rd_eq_rs1", 32'hC0702407, 10'h007, 32'hFFFF_FFFF, 10'h009, 32'h0, 1'b0,
                    10'h007, 32'hFFFF_FFFF, {32'h0, 32'hFFFF_FFFF, 2'b11}};
        vecs[4] = '{"add_wrap", 32'h3FF007FE, 10'h3FF, 32'hFFFF_FFFF, 10'h001, 32'h2, 1'b0,
                    10'h3FE, 32'h1, {32'h2, 32'hFFFF_FFFF, 2'b00}};

        repeat (3) tick();
        check("reset.outputs",
              66'({bus.busy, bus.done, bus.rf_we, bus.alu_tx_start, bus.alu_tx_bit,
                   bus.rf_raddr, bus.rf_waddr, bus.rf_wdata}), 66'(0));
        reset = 1'b0;
        tick();
        check("idle.instr_ready", 66'(bus.instr_ready), 66'(1));
        check("idle.busy", 66'(bus.busy), 66'(0));

        foreach (vecs[i]) begin
            preset(vecs[i].ra, vecs[i].va);
            preset(vecs[i].rb, vecs[i].vb);
            stall_en = vecs[i].stall;
            stalls = 0;
            start_bad = 0;
            ready_bad = 0;
            d0 = done_count;
            issue(vecs[i].instr, vecs[i].name);
            wait_done(d0, vecs[i].name);
            check({vecs[i].name, ".waddr"}, 66'(last_waddr), 66'(vecs[i].exp_addr));
            check({vecs[i].name, ".wdata"}, 66'(last_wdata), 66'(vecs[i].exp_data));
            check({vecs[i].name, ".packet"}, last_pkt, vecs[i].exp_pkt);
            check({vecs[i].name, ".latency"}, 66'(done_cyc - hs_cyc), 66'(102 + stalls));
            check({vecs[i].name, ".we_with_done"}, 66'(we_cyc), 66'(done_cyc));
            check({vecs[i].name, ".start_only_bit0"}, 66'(start_bad), 66'(0));
            check({vecs[i].name, ".ready_low_busy"}, 66'(ready_bad), 66'(0));
            repeat (2) tick();
        end
        stall_en = 1'b0;

        // Back-to-back: valid held high across two instructions
        d0 = done_count;
        h0 = hs_count;
        ready_bad = 0;
        bus.instr = 32'h900BFC05;
        bus.instr_valid = 1'b1;
        wait_hs(h0, "b2b_first");
        bus.instr = 32'h12AF7642;
        wait_done(d0, "b2b_first");
        d1 = done_cyc;
        check("b2b_first.wdata", 66'(last_wdata), 66'(32'h00F0_1200));
        wait_hs(h0 + 1, "b2b_second");
        check("b2b_second.accept_after_done", 66'(hs_cyc - d1), 66'(1));
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        wait_done(d0 + 1, "b2b_second");
        check("b2b_second.waddr", 66'(last_waddr), 66'(10'h242));
        check("b2b_second.wdata", 66'(last_wdata), 66'(32'd8));
        check("b2b.ready_low_busy", 66'(ready_bad), 66'(0));
        repeat (2) tick();

        // Reset in the middle of SEND
        w0 = we_count;
        d0 = done_count;
        issue(32'h12AF7642, "rst");
        t = 0;
        while (tx_cnt < 30 && t < 100) begin
            tick();
            t++;
        end
        check("rst.reached_bit30", 66'(tx_cnt), 66'(30));
        #2;
        check("rst.busy_before", 66'(bus.busy), 66'(1));
        reset = 1'b1;
        #1;
        check("rst.async_outputs", 66'({bus.busy, bus.alu_tx_start, bus.rf_we, bus.done}), 66'(0));
        tick();
        tick();
        reset = 1'b0;
        repeat (150) tick();
        check("rst.no_write", 66'(we_count - w0), 66'(0));
        check("rst.no_done", 66'(done_count - d0), 66'(0));
        d0 = done_count;
        start_bad = 0;
        issue(32'h12AF7642, "rst_after");
        wait_done(d0, "rst_after");
        check("rst_after.wdata", 66'(last_wdata), 66'(32'd8));
        check("rst_after.latency", 66'(done_cyc - hs_cyc), 66'(102));
        check("rst_after.packet", last_pkt, {32'd3, 32'd5, 2'b00});
        repeat (2) tick();

        // Register 0 as source and destination
        preset(10'h000, 32'h55);
        preset(10'h004, 32'h10);
        w0 = we_count;
        d0 = done_count;
        issue(32'h00001000, "zero");
        wait_done(d0, "zero");
`ifdef SEQ_ZERO_REG_EN
        check("zero.packet", last_pkt, {32'h10, 32'h0, 2'b00});
        check("zero.no_write", 66'(we_count - w0), 66'(0));
`else
        check("zero.packet", last_pkt, {32'h10, 32'h55, 2'b00});
        check("zero.write_count", 66'(we_count - w0), 66'(1));
        check("zero.wdata", 66'(last_wdata), 66'(32'h65));
`endif
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
